rd_resp_router: RTL and testbench
=================================

# rd_resp_router

Read-response router downstream of the AR round-robin arbiter. It records, in grant order, which CPU won each AR handshake and the burst length of that read. It then steers the single interconnect R channel back to that CPU and frees the entry on the last beat. It also checks beat count against the recorded length and raises backpressure to the AR arbiter when its order queue is full.

## Interface
Parameters:
- N_CPU, param_pkg value: number of CPU ports.
- ID_WIDTH, param_pkg value: AXI ID width.
- DATA_WIDTH, param_pkg value: R data width.
- RRESP_WIDTH, param_pkg value (4): ACE RRESP width.
- ORD_DEPTH, param_pkg value (4): outstanding-read capacity; power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ar_valid_cpu_i  in  N_CPU  per-CPU AR valid (arbiter inputs).
- ar_ready_cpu_i  in  N_CPU  per-CPU AR ready (arbiter outputs).
- ar_len_o_i  in  8  arbitrated AR length (arbiter output).
- ar_block_o  out  1  1 = order queue full; upstream ANDs ~ar_block_o into the arbiter's downstream ready.
- r_valid_i  in  1  memory-side R valid.
- r_ready_o  out  1  memory-side R ready.
- r_id_i  in  ID_WIDTH  R ID.
- r_data_i  in  DATA_WIDTH  R data.
- r_resp_i  in  RRESP_WIDTH  R response.
- r_last_i  in  1  R last.
- r_valid_cpu_o  out  N_CPU  per-CPU R valid; one-hot or zero.
- r_ready_cpu_i  in  N_CPU  per-CPU R ready.
- r_id_o, r_data_o, r_resp_o, r_last_o  out  as inputs  broadcast to all CPUs; only the addressed CPU sees valid.
- err_o  out  1  sticky protocol-error flag; cleared only by reset.

## Operation
- Push event: `hs = ar_valid_cpu_i & ar_ready_cpu_i`.
  - If hs is non-zero, push {index of set bit, ar_len_o_i} into the order FIFO.
  - If hs has more than one bit set, push the lowest index and set err_o.
- Head entry {idx, len} routes the R channel:
  - `r_valid_cpu_o[idx] = r_valid_i & ~empty`.
  - `r_ready_o = r_ready_cpu_i[idx] & ~empty`.
  - Data, ID, RESP and LAST pass through combinationally.
- FIFO empty:
  - r_ready_o = 0 and r_valid_cpu_o = 0.
  - If r_valid_i is high while empty, set err_o (orphan beat). The beat is not accepted.
- Beat counter `beat_r` (8 bits) increments on each R handshake (r_valid_i & r_ready_o). Handshake with r_last_i = 1:
  - Pop the head and clear beat_r.
  - If beat_r != len, set err_o. The pop still happens.
- Handshake with r_last_i = 0 and beat_r == len: set err_o and keep routing until last.
- r_id_i is not used for routing. The order is strictly in AR-grant order, because the single downstream memory returns reads in order.
- `ar_block_o = full`. A push while full is dropped and sets err_o; upstream gating makes this unreachable in a compliant system.

## Timing
- Reset state, asynchronous on resetn low:
  - pointers = 0, count = 0, beat_r = 0, err_o = 0.
  - This gives empty = 1, ar_block_o = 0, r_ready_o = 0, r_valid_cpu_o = 0, and data outputs = 0 (routing gated by empty).
- Push is registered; the entry is visible at the head the cycle after the AR handshake. R data can never arrive in the same cycle as its AR.
- R routing is zero-latency and combinational from head, r_valid_i and r_ready_cpu_i. There is no registered stage.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, a pop frees a slot and ar_block_o drops the next cycle.
- Pointers are $clog2(ORD_DEPTH) bits and wrap naturally. count is $clog2(ORD_DEPTH)+1 bits; full = (count == ORD_DEPTH).
- Reset asserted mid-burst discards all entries and the partial beat count. Outputs go to reset values asynchronously.
- err_o rises the cycle after the offending event.

## Structure
- param_pkg additions: RRESP_WIDTH = 4, ORD_DEPTH = 4, and `typedef struct packed {logic [$clog2(N_CPU)-1:0] idx; logic [7:0] len;} rd_ord_t`.
- One sub-module, `ord_fifo`: a generic synchronous FIFO of rd_ord_t with push, pop, head, full and empty, using asynchronous active-low reset.
- The top level holds the one-hot-to-index encoder, routing mux, beat counter and error logic.

## Test plan
- Single read: CPU1 AR handshake with len=3, then 4 R beats, last on beat 4 → r_valid_cpu_o = 4'b0010 for all 4 beats, pop after beat 4, empty, err_o = 0.
- Ordering: AR grants CPU2 (len 0), then CPU0 (len 1), then CPU3 (len 0) → R beats go to CPU2, CPU0, CPU0, CPU3 in that order, with no ID dependence.
- Full/backpressure: 4 grants with no R traffic → ar_block_o = 1 after the 4th push. One single-beat R pop → ar_block_o = 0 the next cycle. Also cover a simultaneous push and pop at count 3, after which count stays at 3.
- Backpressure on the CPU side: r_ready_cpu_i[idx] held at 0 for 5 cycles mid-burst → r_ready_o = 0, beat_r frozen, no beat lost.
- Errors, each producing sticky err_o = 1:
  - r_valid_i while empty.
  - r_last_i at beat 2 of len=3.
  - a two-hot AR handshake.
- Async reset asserted mid-burst, with no clock edge → all outputs return to reset values immediately; the next read after reset routes correctly.

Source files
------------

// File: rtl/rd_resp_router_pkg.sv
// rtl/rd_resp_router_pkg.sv - shared parameters and order-queue entry type for rd_resp_router
//
// Purpose: default configuration of the read-response router and the
// {cpu index, burst length} record stored in its order queue.
// Ports: none (package).

package rd_resp_router_pkg;

  localparam int N_CPU       = 4;
  localparam int ID_WIDTH    = 4;
  localparam int DATA_WIDTH  = 32;
  localparam int RRESP_WIDTH = 4;
  localparam int ORD_DEPTH   = 4;

  localparam int IDX_W = $clog2(N_CPU);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [7:0]       len;
  } rd_ord_t;

  // Lowest set bit wins, so a malformed multi-hot grant still maps to one CPU.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CPU-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_CPU - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rd_resp_router_ord_fifo.sv
// rtl/rd_resp_router_ord_fifo.sv - synchronous FIFO of read-order entries
//
// Purpose: holds outstanding reads in AR-grant order.
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   push_i, push_data_i  write one entry (ignored when full)
//   pop_i             drop the head entry (ignored when empty)
//   head_o            current head entry
//   full_o, empty_o   occupancy flags

module ord_fifo
  import rd_resp_router_pkg::*;
#(
  parameter int DEPTH = ORD_DEPTH
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    push_i,
  input  rd_ord_t push_data_i,
  input  logic    pop_i,
  output rd_ord_t head_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  rd_ord_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push against a full queue is dropped even if a pop happens in the same
  // cycle; upstream backpressure keeps this from happening in practice.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/rd_resp_router.sv
// rtl/rd_resp_router.sv - steers the shared R channel back to the CPU that won each AR
//
// Purpose: records AR grant order and burst length, routes R beats to the
// head CPU, frees the entry on the last beat and flags protocol errors.
// Ports:
//   clk, resetn                clock, asynchronous active-low reset
//   ar_valid_cpu_i/ar_ready_cpu_i  per-CPU AR handshake seen at the arbiter
//   ar_len_o_i                 arbitrated burst length
//   ar_block_o                 order queue full, gates the arbiter's ready
//   r_valid_i/r_ready_o, r_id_i/r_data_i/r_resp_i/r_last_i  memory-side R
//   r_valid_cpu_o/r_ready_cpu_i  per-CPU R handshake
//   r_id_o/r_data_o/r_resp_o/r_last_o  R payload broadcast to all CPUs
//   err_o                      sticky protocol error

module rd_resp_router #(
  parameter int N_CPU       = rd_resp_router_pkg::N_CPU,
  parameter int ID_WIDTH    = rd_resp_router_pkg::ID_WIDTH,
  parameter int DATA_WIDTH  = rd_resp_router_pkg::DATA_WIDTH,
  parameter int RRESP_WIDTH = rd_resp_router_pkg::RRESP_WIDTH,
  parameter int ORD_DEPTH   = rd_resp_router_pkg::ORD_DEPTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_CPU-1:0]       ar_valid_cpu_i,
  input  logic [N_CPU-1:0]       ar_ready_cpu_i,
  input  logic [7:0]             ar_len_o_i,
  output logic                   ar_block_o,
  input  logic                   r_valid_i,
  output logic                   r_ready_o,
  input  logic [ID_WIDTH-1:0]    r_id_i,
  input  logic [DATA_WIDTH-1:0]  r_data_i,
  input  logic [RRESP_WIDTH-1:0] r_resp_i,
  input  logic                   r_last_i,
  output logic [N_CPU-1:0]       r_valid_cpu_o,
  input  logic [N_CPU-1:0]       r_ready_cpu_i,
  output logic [ID_WIDTH-1:0]    r_id_o,
  output logic [DATA_WIDTH-1:0]  r_data_o,
  output logic [RRESP_WIDTH-1:0] r_resp_o,
  output logic                   r_last_o,
  output logic                   err_o
);

  import rd_resp_router_pkg::*;

  logic [N_CPU-1:0] hs;
  logic             push, pop, r_hs, multi_hot;
  logic             empty, full;
  rd_ord_t          push_ent, head;
  logic [7:0]       beat_q, beat_d;
  logic             err_q, err_d;

  assign hs        = ar_valid_cpu_i & ar_ready_cpu_i;
  assign push      = |hs;
  assign multi_hot = |(hs & (hs - N_CPU'(1)));
  assign push_ent  = '{idx: lowest_idx(hs), len: ar_len_o_i};

  ord_fifo #(
    .DEPTH(ORD_DEPTH)
  ) u_ord_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (push),
    .push_data_i(push_ent),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (full),
    .empty_o    (empty)
  );

  assign ar_block_o = full;
  assign r_hs       = r_valid_i & r_ready_o;
  assign pop        = r_hs & r_last_i;
  assign err_o      = err_q;

  // Everything on the CPU side is gated by empty so nothing leaks out with no
  // owner, including the payload.
  always_comb begin
    r_valid_cpu_o = '0;
    r_ready_o     = 1'b0;
    r_id_o        = '0;
    r_data_o      = '0;
    r_resp_o      = '0;
    r_last_o      = 1'b0;
    if (!empty) begin
      r_valid_cpu_o[head.idx] = r_valid_i;
      r_ready_o               = r_ready_cpu_i[head.idx];
      r_id_o                  = r_id_i;
      r_data_o                = r_data_i;
      r_resp_o                = r_resp_i;
      r_last_o                = r_last_i;
    end
  end

  // beat_q counts beats already accepted for the head burst, so the last
  // beat must arrive when beat_q equals the recorded len.
  always_comb begin
    beat_d = beat_q;
    if (r_hs) beat_d = r_last_i ? 8'd0 : beat_q + 8'd1;

    err_d = err_q;
    if (multi_hot)                                  err_d = 1'b1;
    if (push && full)                               err_d = 1'b1;
    if (r_valid_i && empty)                         err_d = 1'b1;
    if (r_hs && r_last_i && (beat_q != head.len))   err_d = 1'b1;
    if (r_hs && !r_last_i && (beat_q == head.len))  err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beat_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_rd_resp_router.sv
// tb/tb_rd_resp_router.sv - scoreboard bench for rd_resp_router

module tb_rd_resp_router;

  import rd_resp_router_pkg::*;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [N_CPU-1:0]       ar_valid_cpu_i, ar_ready_cpu_i;
  logic [7:0]             ar_len_o_i;
  logic                   ar_block_o;
  logic                   r_valid_i, r_ready_o;
  logic [ID_WIDTH-1:0]    r_id_i, r_id_o;
  logic [DATA_WIDTH-1:0]  r_data_i, r_data_o;
  logic [RRESP_WIDTH-1:0] r_resp_i, r_resp_o;
  logic                   r_last_i, r_last_o;
  logic [N_CPU-1:0]       r_valid_cpu_o, r_ready_cpu_i;
  logic                   err_o;

  typedef struct {
    int          cpu;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   exp_seq = 0;
  int   r_seq   = 0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  rd_resp_router dut (
    .clk           (clk),
    .resetn        (resetn),
    .ar_valid_cpu_i(ar_valid_cpu_i),
    .ar_ready_cpu_i(ar_ready_cpu_i),
    .ar_len_o_i    (ar_len_o_i),
    .ar_block_o    (ar_block_o),
    .r_valid_i     (r_valid_i),
    .r_ready_o     (r_ready_o),
    .r_id_i        (r_id_i),
    .r_data_i      (r_data_i),
    .r_resp_i      (r_resp_i),
    .r_last_i      (r_last_i),
    .r_valid_cpu_o (r_valid_cpu_o),
    .r_ready_cpu_i (r_ready_cpu_i),
    .r_id_o        (r_id_o),
    .r_data_o      (r_data_o),
    .r_resp_o      (r_resp_o),
    .r_last_o      (r_last_o),
    .err_o         (err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grant one AR; the scoreboard learns which CPU owns the next nbeats beats.
  task automatic ar(input logic [3:0] mask, input int cpu, input logic [7:0] len, input int nbeats);
    exp_t e;
    @(posedge clk); #1;
    ar_valid_cpu_i = mask;
    ar_ready_cpu_i = mask;
    ar_len_o_i     = len;
    for (int k = 0; k < nbeats; k++) begin
      e.cpu  = cpu;
      e.data = 32'hA000 + exp_seq;
      e.last = (k == nbeats - 1);
      exp_q.push_back(e);
      exp_seq++;
    end
    @(posedge clk); #1;
    ar_valid_cpu_i = '0;
    ar_ready_cpu_i = '0;
  endtask

  task automatic drive_r(input logic last);
    r_valid_i = 1'b1;
    r_last_i  = last;
    r_data_i  = 32'hA000 + r_seq;
    r_id_i    = ID_WIDTH'(r_seq * 5);
    r_resp_i  = RRESP_WIDTH'(r_seq);
  endtask

  task automatic rbeat(input logic last);
    bit done = 0;
    @(posedge clk); #1;
    drive_r(last);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (r_ready_o) done = 1;
    end
    if (!done) chk("rbeat_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    r_seq++;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    exp_q.delete();
    exp_seq = r_seq;
    @(posedge clk);
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  // Monitor: every CPU-side handshake must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resetn && ((r_valid_cpu_o & r_ready_cpu_i) != '0)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {28'd0, r_valid_cpu_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("route", {28'd0, r_valid_cpu_o}, {28'd0, 4'(1 << e.cpu)});
        chk("data", r_data_o, e.data);
        chk("last", {31'd0, r_last_o}, {31'd0, e.last});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    ar_valid_cpu_i = '0;
    ar_ready_cpu_i = '0;
    ar_len_o_i     = '0;
    r_valid_i      = 1'b0;
    r_id_i         = '0;
    r_data_i       = '0;
    r_resp_i       = '0;
    r_last_i       = 1'b0;
    r_ready_cpu_i  = '1;
    #12;
    chk("rst_block", {31'd0, ar_block_o}, 32'd0);
    chk("rst_rready", {31'd0, r_ready_o}, 32'd0);
    chk("rst_rvalid", {28'd0, r_valid_cpu_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_data", r_data_o, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // single read, CPU1, len 3
    ar(4'b0010, 1, 8'd3, 4);
    for (int i = 0; i < 4; i++) rbeat(i == 3);
    @(negedge clk);
    chk("single_empty", {31'd0, r_ready_o}, 32'd0);
    chk("single_err", {31'd0, err_o}, 32'd0);

    // ordering by grant, not by ID
    ar(4'b0100, 2, 8'd0, 1);
    ar(4'b0001, 0, 8'd1, 2);
    ar(4'b1000, 3, 8'd0, 1);
    rbeat(1); rbeat(0); rbeat(1); rbeat(1);
    @(negedge clk);
    chk("order_err", {31'd0, err_o}, 32'd0);

    // fill queue, then free one slot
    for (int c = 0; c < 4; c++) ar(4'(1 << c), c, 8'd0, 1);
    @(negedge clk);
    chk("full_block", {31'd0, ar_block_o}, 32'd1);
    rbeat(1);
    @(negedge clk);
    chk("unblock", {31'd0, ar_block_o}, 32'd0);

    // simultaneous push (CPU0) and pop (CPU1 beat) at count 3
    begin
      exp_t e;
      @(posedge clk); #1;
      ar_valid_cpu_i = 4'b0001;
      ar_ready_cpu_i = 4'b0001;
      ar_len_o_i     = 8'd0;
      e.cpu = 0; e.data = 32'hA000 + exp_seq; e.last = 1'b1;
      exp_q.push_back(e);
      exp_seq++;
      drive_r(1'b1);
      @(negedge clk);
      chk("simul_rready", {31'd0, r_ready_o}, 32'd1);
      @(posedge clk); #1;
      ar_valid_cpu_i = '0;
      ar_ready_cpu_i = '0;
      r_valid_i = 1'b0;
      r_last_i  = 1'b0;
      r_seq++;
    end
    @(negedge clk);
    chk("simul_count3", {31'd0, ar_block_o}, 32'd0);
    ar(4'b1000, 3, 8'd0, 1);
    @(negedge clk);
    chk("refill_block", {31'd0, ar_block_o}, 32'd1);
    for (int i = 0; i < 4; i++) rbeat(1);
    @(negedge clk);
    chk("full_err", {31'd0, err_o}, 32'd0);

    // CPU-side backpressure mid-burst
    ar(4'b0001, 0, 8'd3, 4);
    rbeat(0); rbeat(0);
    @(posedge clk); #1;
    drive_r(1'b0);
    r_ready_cpu_i = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rready", {31'd0, r_ready_o}, 32'd0);
      chk("stall_rvalid", {28'd0, r_valid_cpu_o}, 32'h1);
    end
    @(posedge clk); #1;
    r_ready_cpu_i = '1;
    @(negedge clk);
    chk("stall_release", {31'd0, r_ready_o}, 32'd1);
    @(posedge clk); #1;
    r_valid_i = 1'b0;
    r_seq++;
    rbeat(1);
    @(negedge clk);
    chk("stall_err", {31'd0, err_o}, 32'd0);
    chk("stall_empty", {31'd0, r_ready_o}, 32'd0);

    // orphan beat
    @(posedge clk); #1;
    drive_r(1'b1);
    @(negedge clk);
    chk("orphan_rready", {31'd0, r_ready_o}, 32'd0);
    chk("orphan_rvalid", {28'd0, r_valid_cpu_o}, 32'd0);
    chk("orphan_data", r_data_o, 32'd0);
    @(posedge clk); #1;
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    @(negedge clk);
    chk("orphan_err", {31'd0, err_o}, 32'd1);
    do_reset();

    // early last: last on beat 2 of len 3
    @(negedge clk);
    chk("early_pre_err", {31'd0, err_o}, 32'd0);
    ar(4'b0100, 2, 8'd3, 2);
    rbeat(0); rbeat(1);
    @(negedge clk);
    chk("early_err", {31'd0, err_o}, 32'd1);
    chk("early_popped", {31'd0, r_ready_o}, 32'd0);
    do_reset();

    // two-hot grant: lowest index (CPU1) wins
    @(negedge clk);
    chk("twohot_pre_err", {31'd0, err_o}, 32'd0);
    ar(4'b0110, 1, 8'd0, 1);
    @(negedge clk);
    chk("twohot_err", {31'd0, err_o}, 32'd1);
    rbeat(1);
    do_reset();

    // async reset mid-burst, away from any clock edge
    ar(4'b0010, 1, 8'd3, 4);
    rbeat(0);
    @(posedge clk); #1;
    drive_r(1'b0);
    @(negedge clk);
    chk("pre_rst_route", {28'd0, r_valid_cpu_o}, 32'h2);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_rvalid", {28'd0, r_valid_cpu_o}, 32'd0);
    chk("arst_rready", {31'd0, r_ready_o}, 32'd0);
    chk("arst_data", r_data_o, 32'd0);
    chk("arst_last", {31'd0, r_last_o}, 32'd0);
    chk("arst_block", {31'd0, ar_block_o}, 32'd0);
    chk("arst_err", {31'd0, err_o}, 32'd0);
    do_reset();
    ar(4'b1000, 3, 8'd1, 2);
    rbeat(0); rbeat(1);
    @(negedge clk);
    chk("post_rst_err", {31'd0, err_o}, 32'd0);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
